// File: rtl/timer_pkg.sv
// timer_pkg: packed-time field layout, limits, opcodes and channel states shared by the timer core.
package timer_pkg;
    localparam int TIME_W  = 24;
    localparam int HR_W    = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int CS_W    = 7;
    localparam int HR_LSB  = 19;
    localparam int MIN_LSB = 13;
    localparam int SEC_LSB = 7;
    localparam int CS_LSB  = 0;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_START    = 3'd1;
    localparam logic [2:0] OP_STOP     = 3'd2;
    localparam logic [2:0] OP_CLEAR    = 3'd3;
    localparam logic [2:0] OP_LOAD     = 3'd4;
    localparam logic [2:0] OP_SET_UP   = 3'd5;
    localparam logic [2:0] OP_SET_DOWN = 3'd6;
    localparam logic [2:0] OP_RSVD     = 3'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED} state_e;
    function automatic logic time_valid(input logic [TIME_W-1:0] t);
        return t[HR_LSB +: HR_W] <= HR_MAX && t[MIN_LSB +: MIN_W] <= MIN_MAX &&
               t[SEC_LSB +: SEC_W] <= SEC_MAX && t[CS_LSB +: CS_W] <= CS_MAX;
    endfunction
endpackage

// File: rtl/time_digit_counter.sv
// time_digit_counter: one channel's hr:min:sec:cs register with ripple-carry increment and ripple-borrow decrement.
module time_digit_counter
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              dir_i,
    input  logic              load_i,
    input  logic [TIME_W-1:0] load_val_i,
    output logic [TIME_W-1:0] time_o,
    output logic              zero_o
);
    logic [HR_W-1:0]  hr_q, hr_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [CS_W-1:0]  cs_q, cs_d;
    logic cs_top, sec_c, min_c, cs_z, sec_b, min_b;

    assign time_o = {hr_q, min_q, sec_q, cs_q};
    assign zero_o = time_o == '0;
    assign cs_top = cs_q == CS_MAX;
    assign sec_c  = cs_top && sec_q == SEC_MAX;
    assign min_c  = sec_c && min_q == MIN_MAX;
    assign cs_z   = cs_q == '0;
    assign sec_b  = cs_z && sec_q == '0;
    assign min_b  = sec_b && min_q == '0;

    // Decrement is suppressed at zero so the register holds 00:00:00.00.
    always_comb begin
        hr_d  = hr_q;
        min_d = min_q;
        sec_d = sec_q;
        cs_d  = cs_q;
        if (load_i) begin
            hr_d  = load_val_i[HR_LSB +: HR_W];
            min_d = load_val_i[MIN_LSB +: MIN_W];
            sec_d = load_val_i[SEC_LSB +: SEC_W];
            cs_d  = load_val_i[CS_LSB +: CS_W];
        end else if (en_i && !dir_i) begin
            cs_d  = cs_top ? '0 : cs_q + 1'b1;
            sec_d = cs_top ? (sec_q == SEC_MAX ? '0 : sec_q + 1'b1) : sec_q;
            min_d = sec_c ? (min_q == MIN_MAX ? '0 : min_q + 1'b1) : min_q;
            hr_d  = min_c ? (hr_q == HR_MAX ? '0 : hr_q + 1'b1) : hr_q;
        end else if (en_i && !zero_o) begin
            cs_d  = cs_z ? CS_MAX : cs_q - 1'b1;
            sec_d = cs_z ? (sec_q == '0 ? SEC_MAX : sec_q - 1'b1) : sec_q;
            min_d = sec_b ? (min_q == '0 ? MIN_MAX : min_q - 1'b1) : min_q;
            hr_d  = min_b ? hr_q - 1'b1 : hr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_q  <= '0;
            min_q <= '0;
            sec_q <= '0;
            cs_q  <= '0;
        end else begin
            hr_q  <= hr_d;
            min_q <= min_d;
            sec_q <= sec_d;
            cs_q  <= cs_d;
        end
    end
endmodule

// File: rtl/multi_timer_core.sv
// multi_timer_core: CHANNELS independent stopwatch/timer channels on a shared centisecond tick,
// controlled by a single-cycle command port and read through a registered time port.
module multi_timer_core
    import timer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int TICK_DIV = 1000000,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    input  logic [CH_W-1:0]     cmd_chan,
    input  logic [2:0]          cmd_op,
    input  logic [TIME_W-1:0]   cmd_data,
    output logic                cmd_err,
    input  logic [CH_W-1:0]     rd_chan,
    output logic [TIME_W-1:0]   rd_time,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] expired,
    output logic [CHANNELS-1:0] expire_pulse,
    output logic                tick
);
    localparam int DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d, err_q, err_d;
    logic                chan_ok, op_ok, load_ok;
    logic [CH_W-1:0]     rd_chan_q;
    logic [TIME_W-1:0]   ld_val;
    logic [CHANNELS-1:0] dir_q, dir_d, pulse_q, pulse_d, hit, ld, en, zero_w;
    logic [TIME_W-1:0]   time_w [CHANNELS];
    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];

    assign tick         = tick_q;
    assign cmd_err      = err_q;
    assign expire_pulse = pulse_q;
    assign chan_ok      = 32'(cmd_chan) < CHANNELS;
    assign op_ok        = cmd_op != OP_RSVD;
    assign load_ok      = time_valid(cmd_data);
    assign ld_val       = cmd_op == OP_CLEAR ? '0 : cmd_data;
    assign div_d        = div_q == DIV_W'(TICK_DIV - 1) ? '0 : div_q + 1'b1;
    assign tick_d       = div_q == DIV_W'(TICK_DIV - 1);

    // A command addressed to a channel takes precedence over that channel's tick.
    always_comb begin
        err_d = cmd_valid && !(chan_ok && op_ok);
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            dir_d[i]   = dir_q[i];
            hit[i]     = cmd_valid && chan_ok && op_ok && cmd_op != OP_NOP && cmd_chan == CH_W'(i);
            en[i]      = tick_q && state_q[i] == ST_RUN && !hit[i];
            ld[i]      = hit[i] && (cmd_op == OP_CLEAR ||
                         (cmd_op == OP_LOAD && load_ok && state_q[i] != ST_RUN));
            if (hit[i]) begin
                if (cmd_op == OP_LOAD && !ld[i])
                    err_d = 1'b1;
                if (ld[i])
                    state_d[i] = ST_IDLE;
                if (cmd_op == OP_START && (state_q[i] == ST_IDLE || state_q[i] == ST_PAUSED))
                    state_d[i] = dir_q[i] && zero_w[i] ? ST_EXPIRED : ST_RUN;
                if (cmd_op == OP_STOP && state_q[i] == ST_RUN)
                    state_d[i] = ST_PAUSED;
                if ((cmd_op == OP_SET_UP || cmd_op == OP_SET_DOWN) &&
                    (state_q[i] == ST_IDLE || state_q[i] == ST_PAUSED))
                    dir_d[i] = cmd_op == OP_SET_DOWN;
            end else if (en[i] && dir_q[i] && time_w[i] == TIME_W'(1)) begin
                state_d[i] = ST_EXPIRED;
            end
            pulse_d[i] = state_d[i] == ST_EXPIRED && state_q[i] != ST_EXPIRED;
        end
    end

    always_comb begin
        rd_time = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (rd_chan_q == CH_W'(i))
                rd_time = time_w[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= '0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_chan_q <= '0;
            dir_q     <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < CHANNELS; i++)
                state_q[i] <= ST_IDLE;
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            rd_chan_q <= rd_chan;
            dir_q     <= dir_d;
            pulse_q   <= pulse_d;
            for (int i = 0; i < CHANNELS; i++)
                state_q[i] <= state_d[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign running[g] = state_q[g] == ST_RUN;
        assign expired[g] = state_q[g] == ST_EXPIRED;
        time_digit_counter u_cnt (
            .clk        (clk),
            .rst_n      (reset),
            .en_i       (en[g]),
            .dir_i      (dir_q[g]),
            .load_i     (ld[g]),
            .load_val_i (ld_val),
            .time_o     (time_w[g]),
            .zero_o     (zero_w[g])
        );
    end
endmodule

// File: tb/tb_multi_timer_core.sv
// tb_multi_timer_core: directed and randomized checks of multi_timer_core against a centisecond-count reference model.
module tb_multi_timer_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_chan = '0;
    logic [2:0]  cmd_op = '0;
    logic [23:0] cmd_data = '0;
    logic [2:0]  rd_chan = '0;
    logic        cmd_err, tick;
    logic [23:0] rd_time;
    logic [3:0]  running, expired, expire_pulse;

    int errors = 0;
    int checks = 0;

    // Reference model: each channel's time is a plain count of centiseconds since midnight.
    int   m_t [4];
    int   m_st [4];
    bit   m_dir [4];
    int   m_cyc;
    logic e_tick, e_err;
    logic [3:0]  e_run, e_exp, e_pulse;
    logic [23:0] e_rd;

    localparam int DAY = 8640000;

    multi_timer_core #(.CHANNELS(4), .TICK_DIV(4), .CH_W(3)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_chan(cmd_chan), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_err(cmd_err), .rd_chan(rd_chan), .rd_time(rd_time),
        .running(running), .expired(expired), .expire_pulse(expire_pulse), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pack(input int t);
        int h, m, s, c;
        c = t % 100;
        s = (t / 100) % 60;
        m = (t / 6000) % 60;
        h = t / 360000;
        return {h[4:0], m[5:0], s[5:0], c[6:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_t[i] = 0;
            m_st[i] = 0;
            m_dir[i] = 0;
        end
        m_cyc = 0;
        e_tick = 0; e_err = 0; e_run = 0; e_exp = 0; e_pulse = 0; e_rd = 0;
    endtask

    // States: 0 idle, 1 run, 2 paused, 3 expired.
    task automatic model_edge();
        int h, mi, s, c, old;
        bit vld, e;
        h = int'(cmd_data[23:19]); mi = int'(cmd_data[18:13]);
        s = int'(cmd_data[12:7]);  c = int'(cmd_data[6:0]);
        vld = h <= 23 && mi <= 59 && s <= 59 && c <= 99;
        e = cmd_valid && (cmd_chan >= 4 || cmd_op == 7);
        for (int ch = 0; ch < 4; ch++) begin
            old = m_st[ch];
            if (cmd_valid && int'(cmd_chan) == ch && cmd_op >= 1 && cmd_op <= 6) begin
                case (cmd_op)
                    3'd1: if (m_st[ch] == 0 || m_st[ch] == 2) m_st[ch] = (m_dir[ch] && m_t[ch] == 0) ? 3 : 1;
                    3'd2: if (m_st[ch] == 1) m_st[ch] = 2;
                    3'd3: begin m_st[ch] = 0; m_t[ch] = 0; end
                    3'd4: if (m_st[ch] == 1 || !vld) e = 1;
                          else begin m_st[ch] = 0; m_t[ch] = ((h * 60 + mi) * 60 + s) * 100 + c; end
                    default: if (m_st[ch] == 0 || m_st[ch] == 2) m_dir[ch] = cmd_op == 6;
                endcase
            end else if (e_tick && m_st[ch] == 1) begin
                if (!m_dir[ch]) m_t[ch] = (m_t[ch] + 1) % DAY;
                else begin
                    m_t[ch] = m_t[ch] - 1;
                    if (m_t[ch] == 0) m_st[ch] = 3;
                end
            end
            e_pulse[ch] = m_st[ch] == 3 && old != 3;
            e_run[ch] = m_st[ch] == 1;
            e_exp[ch] = m_st[ch] == 3;
        end
        e_err = e;
        m_cyc++;
        e_tick = (m_cyc % 4) == 0;
        e_rd = rd_chan < 4 ? pack(m_t[rd_chan]) : 24'h0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] ch, input logic [2:0] op, input logic [23:0] d);
        cmd_valid = 1; cmd_chan = ch; cmd_op = op; cmd_data = d;
        cycle();
        cmd_valid = 0; cmd_op = 0; cmd_data = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        model_reset();
        #12;
        checks++;
        if ({rd_time, running, expired, expire_pulse, cmd_err, tick} !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {rd_time, running, expired, expire_pulse, cmd_err, tick});
        end
        @(negedge clk);
        reset = 1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            checks++;
            if (tick !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL tick_period: cycle %0d got %b expected %b", i, tick, (i % 4) == 0);
            end
            checks++;
            if ({rd_time, running, expired, expire_pulse, cmd_err} !== 37'h0) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d got %h expected 0", i, {rd_time, running, expired, expire_pulse, cmd_err});
            end
        end
    endtask

    task automatic test_expire();
        int ticks = 0;
        bit found = 0;
        rd_chan = 1;
        cmd(1, 3'd4, 24'h000003);
        cmd(1, 3'd6, 24'h0);
        cmd(1, 3'd1, 24'h0);
        checks++;
        if (running[1] !== 1'b1) begin errors++; $display("FAIL down_start: running[1] got %b expected 1", running[1]); end
        for (int i = 0; i < 40 && !found; i++) begin
            if (e_tick) ticks++;
            cycle();
            checks++;
            if (expire_pulse !== e_pulse || rd_time !== e_rd) begin
                errors++;
                $display("FAIL down_count: pulse %b rd %h expected pulse %b rd %h", expire_pulse, rd_time, e_pulse, e_rd);
            end
            if (expire_pulse[1]) found = 1;
        end
        checks++;
        if (!found || ticks != 3) begin errors++; $display("FAIL expire_timing: found %0d after %0d ticks expected 1 after 3", found, ticks); end
        checks++;
        if (rd_time !== 24'h0 || expired[1] !== 1'b1) begin
            errors++; $display("FAIL expire_state: rd %h expired %b expected 0 and 1", rd_time, expired[1]);
        end
        cycle();
        checks++;
        if (expire_pulse[1] !== 1'b0 || expired[1] !== 1'b1) begin
            errors++; $display("FAIL pulse_width: pulse %b expired %b expected 0 and 1", expire_pulse[1], expired[1]);
        end
        cmd(1, 3'd1, 24'h0);
        checks++;
        if (expired[1] !== 1'b1 || running[1] !== 1'b0) begin
            errors++; $display("FAIL start_expired: expired %b running %b expected 1 and 0", expired[1], running[1]);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        rd_chan = 0;
        cmd(0, 3'd4, pack(DAY - 2));
        cmd(0, 3'd1, 24'h0);
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (e_tick) n++;
            cycle();
            checks++;
            if (rd_time !== e_rd) begin errors++; $display("FAIL up_count: rd %h expected %h", rd_time, e_rd); end
        end
        checks++;
        if (rd_time !== 24'h0 || running[0] !== 1'b1) begin
            errors++; $display("FAIL wrap: rd %h running %b expected 0 and 1", rd_time, running[0]);
        end
    endtask

    task automatic test_errors();
        rd_chan = 2;
        cmd(2, 3'd4, 24'h000100);
        checks++;
        if (cmd_err !== 1'b0 || rd_time !== 24'h000100) begin
            errors++; $display("FAIL good_load: err %b rd %h expected 0 and 000100", cmd_err, rd_time);
        end
        cmd(2, 3'd4, {5'd1, 6'd60, 6'd0, 7'd0});
        checks++;
        if (cmd_err !== 1'b1 || rd_time !== 24'h000100) begin
            errors++; $display("FAIL bad_load: err %b rd %h expected 1 and 000100", cmd_err, rd_time);
        end
        cycle();
        checks++;
        if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_width: err %b expected 0", cmd_err); end
        cmd(3'd5, 3'd1, 24'h0);
        checks++;
        if (cmd_err !== 1'b1 || running !== e_run || rd_time !== 24'h000100) begin
            errors++; $display("FAIL bad_chan: err %b running %b rd %h expected 1 %b 000100", cmd_err, running, rd_time, e_run);
        end
        cmd(2, 3'd7, 24'h0);
        checks++;
        if (cmd_err !== 1'b1 || running !== e_run || expired !== e_exp) begin
            errors++; $display("FAIL bad_op: err %b running %b expired %b expected 1 %b %b", cmd_err, running, expired, e_run, e_exp);
        end
        cmd(0, 3'd4, 24'h0);
        checks++;
        if (cmd_err !== 1'b1 || running[0] !== 1'b1) begin
            errors++; $display("FAIL load_in_run: err %b running %b expected 1 and 1", cmd_err, running[0]);
        end
    endtask

    task automatic test_tick_collision();
        int t3, t0;
        cmd(3, 3'd5, 24'h0);
        cmd(3, 3'd3, 24'h0);
        cmd(3, 3'd1, 24'h0);
        for (int i = 0; i < 8 && !e_tick; i++) cycle();
        checks++;
        if (!e_tick || tick !== 1'b1) begin errors++; $display("FAIL tick_wait: tick %b expected 1", tick); end
        t3 = m_t[3];
        t0 = m_t[0];
        rd_chan = 3;
        cmd(3, 3'd2, 24'h0);
        checks++;
        if (rd_time !== pack(t3) || running[3] !== 1'b0) begin
            errors++; $display("FAIL stop_on_tick: rd %h running %b expected %h and 0", rd_time, running[3], pack(t3));
        end
        rd_chan = 0;
        cycle();
        checks++;
        if (rd_time !== pack(t0 + 1) || running[0] !== 1'b1) begin
            errors++; $display("FAIL other_chan_tick: rd %h running %b expected %h and 1", rd_time, running[0], pack(t0 + 1));
        end
    endtask

    task automatic test_async_reset();
        cmd(3, 3'd1, 24'h0);
        repeat (5) cycle();
        checks++;
        if (running[0] !== 1'b1 || running[3] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_run: running %b expected ch0 and ch3 set", running);
        end
        #2 reset = 0;
        #1;
        checks++;
        if ({rd_time, running, expired, expire_pulse, cmd_err, tick} !== 38'h0) begin
            errors++; $display("FAIL async_reset: got %h expected 0", {rd_time, running, expired, expire_pulse, cmd_err, tick});
        end
        @(posedge clk);
        #1;
        checks++;
        if (expire_pulse !== 4'h0 || running !== 4'h0) begin
            errors++; $display("FAIL reset_hold: pulse %b running %b expected 0", expire_pulse, running);
        end
        model_reset();
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            rd_chan = 3'(i % 4);
            cycle();
            checks++;
            if (rd_time !== e_rd || running !== e_run || tick !== e_tick) begin
                errors++; $display("FAIL post_reset: rd %h running %b tick %b expected %h %b %b", rd_time, running, tick, e_rd, e_run, e_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cmd_valid = $urandom_range(0, 2) == 0;
            cmd_chan = 3'($urandom_range(0, 5));
            cmd_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: cmd_data = pack($urandom_range(0, DAY - 1));
                1: cmd_data = pack($urandom_range(0, 12));
                default: cmd_data = 24'($urandom);
            endcase
            rd_chan = 3'($urandom_range(0, 3));
            cycle();
            checks++;
            if (running !== e_run) begin errors++; $display("FAIL rnd_running: cycle %0d got %b expected %b", i, running, e_run); end
            checks++;
            if (expired !== e_exp) begin errors++; $display("FAIL rnd_expired: cycle %0d got %b expected %b", i, expired, e_exp); end
            checks++;
            if (expire_pulse !== e_pulse) begin errors++; $display("FAIL rnd_pulse: cycle %0d got %b expected %b", i, expire_pulse, e_pulse); end
            checks++;
            if (cmd_err !== e_err) begin errors++; $display("FAIL rnd_err: cycle %0d got %b expected %b", i, cmd_err, e_err); end
            checks++;
            if (tick !== e_tick) begin errors++; $display("FAIL rnd_tick: cycle %0d got %b expected %b", i, tick, e_tick); end
            checks++;
            if (rd_time !== e_rd) begin errors++; $display("FAIL rnd_rd_time: cycle %0d got %h expected %h", i, rd_time, e_rd); end
        end
        cmd_valid = 0;
    endtask

    initial begin
        test_reset();
        test_expire();
        test_wrap();
        test_errors();
        test_tick_collision();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/multi_timer_core.md
# multi_timer_core

Parametrised timekeeping core with CHANNELS independent channels. Each channel runs as an up-counting stopwatch or a down-counting timer on a shared centisecond tick generated internally from `clk`. A single-cycle command port controls the channels, and a read port returns any channel's packed time to the display path. The core replaces the fixed one-stopwatch/one-timer arrangement, and its read output feeds the existing binary-to-BCD and display chain.

## Interface
- CHANNELS, 4: number of independent channels, 1..16
- TICK_DIV, 1000000: `clk` cycles per centisecond tick (100 MHz → 10 ms); must be ≥ 2
- CH_W, $clog2(CHANNELS) (min 1): channel index width
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command strobe, one cycle per command
- `cmd_chan`  in  CH_W  target channel
- `cmd_op`  in  3  0 NOP, 1 START, 2 STOP, 3 CLEAR, 4 LOAD, 5 SET_UP, 6 SET_DOWN; 7 reserved
- `cmd_data`  in  24  LOAD value, packed time
- `cmd_err`  out  1  one-cycle pulse: bad channel, bad opcode, or out-of-range LOAD
- `rd_chan`  in  CH_W  channel to read
- `rd_time`  out  24  registered packed time of `rd_chan`
- `running`  out  CHANNELS  per-channel RUN indicator
- `expired`  out  CHANNELS  per-channel EXPIRED level
- `expire_pulse`  out  CHANNELS  one-cycle pulse on entry to EXPIRED
- `tick`  out  1  centisecond tick strobe, for debug and for the display blink

## Operation
- Packed time fields:
  - hr [23:19], 0..23
  - min [18:13], 0..59
  - sec [12:7], 0..59
  - cs [6:0], 0..99
- Per-channel state:
  - time register
  - dir bit (0 = up, 1 = down)
  - FSM with states IDLE, RUN, PAUSED, EXPIRED
- Transitions (all other op/state pairs leave state unchanged, no error):
  - START: IDLE/PAUSED → RUN. In down mode with time == 0, go to EXPIRED instead.
  - STOP: RUN → PAUSED.
  - CLEAR: any state → IDLE, time = 0.
  - LOAD: any state except RUN → IDLE, time = `cmd_data`. In RUN, ignored and `cmd_err` pulses.
  - SET_UP / SET_DOWN: write dir in IDLE or PAUSED only; otherwise ignored.
  - EXPIRED → IDLE only on CLEAR or LOAD.
- Counting applies only in RUN, on the tick:
  - Up: cs → sec → min → hr ripple carry. 23:59:59.99 wraps to 00:00:00.00 and stays in RUN.
  - Down: ripple borrow. On reaching 00:00:00.00, the channel enters EXPIRED on the same edge, `expire_pulse` fires for one cycle, and time holds at 0.
- LOAD validation: any field out of range → rejected, `cmd_err` pulses, channel unchanged.
- `cmd_chan` ≥ CHANNELS or opcode 7 → `cmd_err` pulses, nothing changes.
- Simultaneous tick and command on the same channel: the command wins and the tick is dropped for that channel only. Other channels still count.

## Timing
- Reset values, asserted asynchronously when `reset` is low:
  - every channel IDLE, time 0, dir up
  - `rd_time` 0; `running`, `expired`, `expire_pulse`, `cmd_err`, `tick` all 0
  - tick divider counter 0
- Tick: `tick` is high for one cycle every TICK_DIV cycles. The first tick occurs TICK_DIV cycles after reset release.
- Commands are sampled at the edge where `cmd_valid` is high. The effect is visible in `running`/`expired` after that edge. No ready signal; one command per cycle is always accepted. `cmd_err` is asserted the cycle after the offending command.
- `rd_time` has 1-cycle latency from `rd_chan`, and reflects the time after the update made at that same edge.
- `expire_pulse` is coincident with the `expired` rising edge.
- Reset during RUN aborts immediately; no expire pulse is generated.

## Structure
- Package `timer_pkg` holds:
  - field widths and bit positions
  - limits: 23, 59, 99
  - opcode localparams
  - FSM state enum
  - function `time_valid(t)`
- Sub-module `time_digit_counter`, one instance per channel: time register plus increment/decrement ripple logic. Inputs are `en`, `dir`, `load`, `load_val`; outputs are `time` and `zero`. The FSM, tick divider, and command decode stay in `multi_timer_core`.

## Test plan
Bench uses TICK_DIV = 4, CHANNELS = 4.
- Reset release, then 20 cycles idle → `tick` pulses at cycles 4, 8, 12…; all outputs 0.
- LOAD ch1 00:00:00.03 (0x000003), SET_DOWN ch1, START ch1 → after 3 ticks `rd_time` == 0. `expired[1]` and a one-cycle `expire_pulse[1]` assert on the 3rd tick edge. A further START leaves ch1 in EXPIRED.
- LOAD ch0 23:59:59.98, START (up) → 2 ticks later ch0 reads 00:00:00.00 with `running[0]` still 1.
- LOAD ch2 with min = 60 → `cmd_err` pulses; ch2 time unchanged. Same result for `cmd_chan` = 5 at CHANNELS = 4 (with CH_W = 3).
- START ch3; issue STOP ch3 on a tick cycle → ch3 does not advance on that tick; ch0 still advances on it.
- Run ch0 and ch3, pull `reset` low mid-count asynchronously (between edges) → all state clears immediately; no `expire_pulse`.
